// File: rtl/led_pwm_if.sv
// -----------------------------------------------------------------------------
// led_pwm_if -- duty-write port of the LED PWM driver.
//
// Signals
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master slave can accept a write this cycle
//   wr_idx    master -> slave  target channel (IDX_W bits)
//   wr_duty   master -> slave  new duty for the channel (DUTY_W bits)
//
// Handshake: a write transfers on every rising clk edge where wr_valid and
// wr_ready are both high. The master holds wr_idx/wr_duty stable while
// wr_valid is high and not yet accepted. wr_ready may fall without wr_valid
// being high; the master must not wait for wr_ready before raising wr_valid.
// -----------------------------------------------------------------------------
interface led_pwm_if #(
   parameter int IDX_W  = 3,
   parameter int DUTY_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [IDX_W-1:0]  wr_idx;
   logic [DUTY_W-1:0] wr_duty;

   modport master (output wr_valid, output wr_idx, output wr_duty, input wr_ready);
   modport slave  (input wr_valid, input wr_idx, input wr_duty, output wr_ready);
endinterface

// File: rtl/led_pwm.sv
// -----------------------------------------------------------------------------
// led_pwm -- per-LED PWM brightness driver for the LED bank.
//
// Duty values arrive over the write port into shadow (pending) registers and
// are copied into the active registers only at the frame boundary, so a frame
// is never torn. A frame is 2^DUTY_W phase slots of PRESCALE clocks each.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   wr           led_pwm_if.slave write port (wr_ready is low only in the
//                commit cycle, once per frame)
//   enable       global output enable; 0 forces every LED off
//   led          registered PWM outputs, one per channel
//   frame_start  one-cycle pulse on the first cycle of each frame's led output
//
// Parameters: PRESCALE must be >= 2; 2^IDX_W must be >= N_LEDS.
// -----------------------------------------------------------------------------
module led_pwm #(
   parameter int N_LEDS   = 8,
   parameter int DUTY_W   = 8,
   parameter int PRESCALE = 97,
   parameter int IDX_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   led_pwm_if.slave          wr,
   input  logic              enable,
   output logic [N_LEDS-1:0] led,
   output logic              frame_start
);

   localparam int                PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] PHASE_LAST = '1;

   logic [PRE_W-1:0]  pre_cnt;
   logic [DUTY_W-1:0] phase;
   logic [DUTY_W-1:0] phase_nxt;
   logic              tick;
   logic              commit;
   logic              wr_fire;

   logic [DUTY_W-1:0] pending    [N_LEDS];
   logic [DUTY_W-1:0] active     [N_LEDS];
   logic [DUTY_W-1:0] active_nxt [N_LEDS];

   assign tick   = (pre_cnt == PRE_LAST);
   assign commit = tick && (phase == PHASE_LAST);

   // The commit cycle reads every pending register, so writes are refused for
   // that single cycle; a held request completes on the next cycle.
   assign wr.wr_ready = ~commit;
   assign wr_fire     = wr.wr_valid && wr.wr_ready;

   // Phase and duties as they will be after this edge. The led register is
   // computed from these so that, in the cycle frame_start is high, led
   // already shows phase 0 with the freshly committed duties.
   always_comb begin
      phase_nxt = phase;
      if (tick) begin
         phase_nxt = phase + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         active_nxt[i] = commit ? pending[i] : active[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         phase   <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         phase   <= phase_nxt;
      end
   end

   // An index with no matching channel completes the handshake but matches
   // no register, so nothing changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_LEDS; i++) begin
            pending[i] <= '0;
            active[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            if (wr_fire && (wr.wr_idx == IDX_W'(i))) begin
               pending[i] <= wr.wr_duty;
            end
            active[i] <= active_nxt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led         <= '0;
         frame_start <= 1'b0;
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            led[i] <= enable && (phase_nxt < active_nxt[i]);
         end
         frame_start <= commit;
      end
   end

endmodule
